pp_frame_sequencer: RTL and testbench



---
 rtl/pp_frame_sequencer_if.sv | 31 +++
 rtl/pp_frame_sequencer.sv | 159 +++++++++++++++
 tb/tb_pp_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_frame_sequencer_if.sv
// Handshake and result-tracking bundle between the frame sequencer, the
// upstream pixel source, the controlled disparity stage and downstream logic.
interface pp_frame_sequencer_if #(
  parameter int CW = 10,
  parameter int RW = 9
) ();

  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          clken;
  logic          enable;
  logic          dp_valid;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          out_eol;
  logic          out_eof;

  // Sequencer side: owns the pipeline controls and the result position.
  modport master (
    input  in_valid, out_ready, dp_valid,
    output in_ready, clken, enable, out_col, out_row, out_eol, out_eof
  );

  // Environment side: pixel source, stage and downstream consumer.
  modport slave (
    output in_valid, out_ready, dp_valid,
    input  in_ready, clken, enable, out_col, out_row, out_eol, out_eof
  );

endinterface

// File: rtl/pp_frame_sequencer.sv
// Frame sequencer for the disparity-selection stage: feeds one frame of
// pixels, flushes the stage with bubbles, and labels every result with its
// raster position plus end-of-line / end-of-frame markers.
module pp_frame_sequencer #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CW       = 10,
  parameter int RW       = 9,
  parameter int PIPE_LAT = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  pp_frame_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int FW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_in_col;
  logic [RW-1:0]   r_in_row;
  logic [CW-1:0]   r_out_col;
  logic [RW-1:0]   r_out_row;
  logic            r_out_full;
  logic [FW-1:0]   r_flush_cnt;
  logic            r_err;

  logic            w_in_ready;
  logic            w_clken;
  logic            w_enable;
  logic            w_done;
  logic            w_in_last;
  logic            w_out_last;
  logic            w_count;
  logic            w_frame_go;

  assign w_in_last  = (r_in_col == CW'(IMG_W - 1)) && (r_in_row == RW'(IMG_H - 1));
  assign w_out_last = (r_out_col == CW'(IMG_W - 1)) && (r_out_row == RW'(IMG_H - 1));
  assign w_count    = bus.dp_valid & w_clken;
  assign w_frame_go = (r_state == ST_IDLE) && start;

  // State register.
  // NOTE: reset is synchronous, so it lives inside the clocked branch and
  // start arriving together with rst==0 simply loses.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and pipeline control decode.
  // NOTE: every output of this block is defaulted first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_clken    = 1'b0;
    w_enable   = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        w_in_ready = bus.out_ready;
        w_clken    = bus.in_valid & bus.out_ready;
        w_enable   = w_clken;
        if (w_clken && w_in_last) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Bubbles: the stage advances but enable stays low.
        w_clken = bus.out_ready;
        if (w_clken && (r_flush_cnt == FW'(1))) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Input/output raster counters and flush countdown.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_col    <= '0;
      r_in_row    <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_out_full  <= 1'b0;
      r_flush_cnt <= '0;
    end else if (w_frame_go) begin
      r_in_col    <= '0;
      r_in_row    <= '0;
      r_out_col   <= '0;
      r_out_row   <= '0;
      r_out_full  <= 1'b0;
    end else begin
      if (w_enable) begin
        if (r_in_col == CW'(IMG_W - 1)) begin
          r_in_col <= '0;
          r_in_row <= (r_in_row == RW'(IMG_H - 1)) ? '0 : r_in_row + RW'(1);
        end else begin
          r_in_col <= r_in_col + CW'(1);
        end
      end

      if ((r_state == ST_RUN) && w_clken && w_in_last)
        r_flush_cnt <= FW'(PIPE_LAT);
      else if ((r_state == ST_FLUSH) && w_clken)
        r_flush_cnt <= r_flush_cnt - FW'(1);

      if (w_count) begin
        if (r_out_col == CW'(IMG_W - 1)) begin
          r_out_col <= '0;
          r_out_row <= (r_out_row == RW'(IMG_H - 1)) ? '0 : r_out_row + RW'(1);
        end else begin
          r_out_col <= r_out_col + CW'(1);
        end
        if (w_out_last) r_out_full <= 1'b1;
      end
    end
  end

  // Sticky error: a result beyond the frame, or any valid while idle.
  always_ff @(posedge clk) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_frame_go)
      r_err <= 1'b0;
    else if ((w_count && r_out_full) || ((r_state == ST_IDLE) && bus.dp_valid))
      r_err <= 1'b1;
  end

  assign bus.in_ready = w_in_ready;
  assign bus.clken    = w_clken;
  assign bus.enable   = w_enable;
  assign bus.out_col  = r_out_col;
  assign bus.out_row  = r_out_row;
  assign bus.out_eol  = bus.dp_valid & (r_out_col == CW'(IMG_W - 1));
  assign bus.out_eof  = bus.out_eol & (r_out_row == RW'(IMG_H - 1));

  assign busy = (r_state != ST_IDLE);
  assign done = w_done;
  assign err  = r_err;

endmodule

// File: tb/tb_pp_frame_sequencer.sv
// Directed bench for pp_frame_sequencer on a 4x2 frame with a 7-deep stage
// model that advances on clken and reports dp_valid from its last slot.
module tb_pp_frame_sequencer;

  localparam int IMG_W    = 4;
  localparam int IMG_H    = 2;
  localparam int CW       = 3;
  localparam int RW       = 2;
  localparam int PIPE_LAT = 7;

  logic clk = 1'b0;
  logic r_rst = 1'b0;
  logic r_start = 1'b0;
  logic r_in_valid = 1'b1;
  logic r_out_ready = 1'b1;
  logic r_force = 1'b0;
  logic busy, done, err;
  logic [PIPE_LAT-1:0] r_pipe;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int n_hs = 0, n_bub = 0, n_res = 0, n_eol = 0, n_eof = 0, n_done = 0;
  int m_col = 0, m_row = 0;

  pp_frame_sequencer_if #(.CW(CW), .RW(RW)) bus ();

  pp_frame_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .RW(RW), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk  (clk),
    .rst  (r_rst),
    .start(r_start),
    .bus  (bus.master),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  assign bus.in_valid  = r_in_valid;
  assign bus.out_ready = r_out_ready;
  assign bus.dp_valid  = r_pipe[PIPE_LAT-1] | r_force;

  // Stage model: enable travels PIPE_LAT clken-qualified edges.
  always @(posedge clk) begin
    if (!r_rst)         r_pipe <= '0;
    else if (bus.clken) r_pipe <= {r_pipe[PIPE_LAT-2:0], bus.enable};
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_hs = 0; n_bub = 0; n_res = 0; n_eol = 0; n_eof = 0; n_done = 0;
    m_col = 0; m_row = 0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", (n_done > 0) ? 1 : 0, 1);
    repeat (3) tick();
  endtask

  task automatic frame_totals(input string tag, input int dur);
    check({tag, "_handshakes"}, n_hs, IMG_W * IMG_H);
    check({tag, "_bubbles"}, n_bub, PIPE_LAT);
    check({tag, "_results"}, n_res, IMG_W * IMG_H);
    check({tag, "_eol"}, n_eol, IMG_H);
    check({tag, "_eof"}, n_eof, 1);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_duration"}, done_cyc - start_cyc + 1, dur);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // Per-cycle monitor: handshakes, bubbles, and raster order of results.
  always @(negedge clk) begin
    cyc++;
    if (r_rst) begin
      if (r_start && !busy) start_cyc = cyc;
      if (bus.in_valid && bus.in_ready) n_hs++;
      if (bus.clken && !bus.enable) n_bub++;
      if (bus.dp_valid && bus.clken) begin
        check("res_col", int'(bus.out_col), m_col);
        check("res_row", int'(bus.out_row), m_row);
        check("res_eol", int'(bus.out_eol), (m_col == IMG_W - 1) ? 1 : 0);
        check("res_eof", int'(bus.out_eof),
              (m_col == IMG_W - 1 && m_row == IMG_H - 1) ? 1 : 0);
        if (bus.out_eol) n_eol++;
        if (bus.out_eof) n_eof++;
        n_res++;
        if (m_col == IMG_W - 1) begin
          m_col = 0;
          m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    // Reset state.
    tick();
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_clken", int'(bus.clken), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_out_col", int'(bus.out_col), 0);
    check("rst_out_row", int'(bus.out_row), 0);
    tick();
    r_rst = 1'b1;
    tick();

    // Baseline: no stalls.
    clear_stats();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    wait_done(100);
    frame_totals("base", IMG_W * IMG_H + PIPE_LAT + 2);

    // in_valid toggling every cycle.
    clear_stats();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    for (int k = 0; k < 100 && n_done == 0; k++) begin
      r_in_valid = ~r_in_valid;
      tick();
    end
    r_in_valid = 1'b1;
    wait_done(50);
    check("toggle_handshakes", n_hs, IMG_W * IMG_H);
    check("toggle_bubbles", n_bub, PIPE_LAT);
    check("toggle_results", n_res, IMG_W * IMG_H);
    check("toggle_eof", n_eof, 1);
    check("toggle_done_pulses", n_done, 1);
    check("toggle_err", int'(err), 0);

    // out_ready stalls: 5 cycles mid-row, 5 cycles during flush.
    clear_stats();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    tick();
    tick();
    r_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_run_clken", int'(bus.clken), 0);
      check("stall_run_in_ready", int'(bus.in_ready), 0);
      check("stall_run_hs", n_hs, 2);
      tick();
    end
    r_out_ready = 1'b1;
    repeat (8) tick();
    r_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_flush_clken", int'(bus.clken), 0);
      check("stall_flush_dp_valid", int'(bus.dp_valid), 1);
      check("stall_flush_col", int'(bus.out_col), 3);
      check("stall_flush_row", int'(bus.out_row), 0);
      check("stall_flush_results", n_res, 3);
      tick();
    end
    r_out_ready = 1'b1;
    wait_done(100);
    frame_totals("stall", IMG_W * IMG_H + PIPE_LAT + 2 + 10);

    // Reset after 5 accepted pixels aborts the frame.
    clear_stats();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    repeat (5) tick();
    r_rst = 1'b0;
    tick();
    r_rst = 1'b1;
    @(negedge clk);
    check("abort_hs_before", n_hs, 5);
    check("abort_busy", int'(busy), 0);
    check("abort_clken", int'(bus.clken), 0);
    check("abort_in_ready", int'(bus.in_ready), 0);
    check("abort_out_col", int'(bus.out_col), 0);
    check("abort_out_row", int'(bus.out_row), 0);
    repeat (5) tick();
    check("abort_no_done", n_done, 0);
    check("abort_err", int'(err), 0);
    clear_stats();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    wait_done(100);
    frame_totals("after_abort", IMG_W * IMG_H + PIPE_LAT + 2);

    // start pulses during RUN and FLUSH are ignored.
    clear_stats();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    repeat (2) tick();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    repeat (7) tick();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    wait_done(100);
    repeat (5) tick();
    frame_totals("restart_ignored", IMG_W * IMG_H + PIPE_LAT + 2);

    // dp_valid while idle sets a sticky err, cleared by start.
    r_force = 1'b1;
    tick();
    r_force = 1'b0;
    @(negedge clk);
    check("idle_valid_err", int'(err), 1);
    repeat (3) tick();
    check("idle_valid_err_held", int'(err), 1);
    clear_stats();
    r_start = 1'b1;
    tick();
    r_start = 1'b0;
    @(negedge clk);
    check("start_clears_err", int'(err), 0);
    wait_done(100);
    check("post_err_results", n_res, IMG_W * IMG_H);
    check("post_err_err", int'(err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
